uart_rx_param: RTL and testbench

- Parametrised UART receiver: the successor to the fixed 8-bit, fixed-divisor receiver.
- Configurable divisor, data width, parity mode and stop-bit count.
- Includes a metastability synchroniser, false-start rejection, framing/parity/overrun flags, and a valid/ready output handshake with a one-word holding register.
- Sits between the board RX pin and any byte consumer (FIFO, command decoder).

---
 rtl/uart_rx_param.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver. It has a 2-flop input synchroniser,
//            false-start rejection, optional parity, 1 or 2 stop bits,
//            framing/parity/overrun flags and a one-word valid/ready
//            holding register.
// Options  : define UART_RX_BREAK_DETECT_EN to add the rx_break output and
//            to swallow line breaks instead of delivering them as frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Sin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 rx_break,
`endif
  output logic                 busy
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_BITS);

  localparam logic [TIMER_W-1:0] HALF_TICK = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
`ifdef UART_RX_BREAK_DETECT_EN
    S_BREAK_WAIT = 3'd5,
`endif
    S_STOP       = 3'd4
  } state_t;

  // Synchroniser
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic rx_s;

  // Receive FSM
  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 armed_q, armed_d;
  logic                 frame_done;
  logic                 frame_is_break;

  // Holding register
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit_q, par_bit_d;
  logic stop0_q, stop0_d;
  logic break_q, break_d;
`endif

  assign rx_s = sync2_q;

  // Next-state logic for the receive FSM: timing, sampling and frame assembly
  always_comb begin
    sync1_d        = Sin;
    sync2_d        = sync1_q;
    state_d        = state_q;
    timer_d        = timer_q + 1'b1;
    bit_idx_d      = bit_idx_q;
    stop_cnt_d     = stop_cnt_q;
    shift_d        = shift_q;
    perr_acc_d     = perr_acc_q;
    ferr_acc_d     = ferr_acc_q;
    armed_d        = armed_q;
    frame_done     = 1'b0;
    frame_is_break = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    par_bit_d      = par_bit_q;
    stop0_d        = stop0_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        // A start is only accepted after the line has been seen high, so a
        // line held low after a frame is not read as a stream of frames.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = S_START;
          armed_d    = 1'b0;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (timer_q == HALF_TICK) begin
          timer_d = '0;
          if (rx_s) begin
            // Line went back high before mid start bit: a glitch.
            state_d = S_IDLE;
            armed_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (timer_q == FULL_TICK) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (timer_q == FULL_TICK) begin
          timer_d    = '0;
          perr_acc_d = (((^shift_q) ^ rx_s) != (PARITY_ODD != 0));
`ifdef UART_RX_BREAK_DETECT_EN
          par_bit_d  = rx_s;
`endif
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == FULL_TICK) begin
          timer_d = '0;
          if (!rx_s) begin
            ferr_acc_d = 1'b1;
          end
`ifdef UART_RX_BREAK_DETECT_EN
          if (!stop_cnt_q) begin
            stop0_d = rx_s;
          end
`endif
          if ((STOP_BITS == 1) || stop_cnt_q) begin
            frame_done = 1'b1;
            state_d    = S_IDLE;
            // A high final stop bit counts as the idle sample, so a start
            // bit right after mid-stop is picked up without delay.
            armed_d    = rx_s;
`ifdef UART_RX_BREAK_DETECT_EN
            frame_is_break = (shift_q == '0)
                           && ((PARITY_EN == 0) || !par_bit_q)
                           && !(stop_cnt_q ? stop0_q : rx_s);
            if (frame_is_break) begin
              state_d = S_BREAK_WAIT;
            end
`endif
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BREAK_WAIT: begin
        timer_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
          armed_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Holding register: load completed frames, drop them when full, handshake out
  always_comb begin
    accept  = valid_q & rx_ready;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = valid_q & ~accept;
    ovr_d   = ovr_q & ~accept;
`ifdef UART_RX_BREAK_DETECT_EN
    break_d = frame_done & frame_is_break;
`endif
    if (frame_done && !frame_is_break) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        perr_d  = perr_acc_q;
        ferr_d  = ferr_acc_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State register for synchroniser, FSM and holding register
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q  <= 1'b0;
      stop0_q    <= 1'b0;
      break_q    <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
      par_bit_q  <= par_bit_d;
      stop0_q    <= stop0_d;
      break_q    <= break_d;
`endif
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign rx_break   = break_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Bench for uart_rx_param. It uses three receiver configurations
//            that share the clock and reset. A frame-level model queues the
//            expected words, and one compare process checks every cycle in
//            which a word is held.
// Options  : honours UART_RX_BREAK_DETECT_EN to match the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DB   [3] = '{8, 7, 8};
  localparam int PEN  [3] = '{1, 0, 1};
  localparam int PODD [3] = '{1, 1, 0};
  localparam int SB   [3] = '{1, 2, 1};

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic [2:0] sin, rdy;
  logic [2:0] rv, pe, fe, ov, bz, brk;
  logic [7:0] rd_a, rd_c;
  logic [6:0] rd_b;

  exp_t expq [3][$];
  int   exp_ovr [3];
  int   vcnt [3];
  int   bcnt [3];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                  .PARITY_ODD(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .Reset(Reset), .Sin(sin[0]), .rx_data(rd_a), .rx_valid(rv[0]),
    .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk[0]),
`endif
    .busy(bz[0]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0),
                  .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .Reset(Reset), .Sin(sin[1]), .rx_data(rd_b), .rx_valid(rv[1]),
    .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk[1]),
`endif
    .busy(bz[1]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                  .PARITY_ODD(0), .STOP_BITS(1)) dut_c (
    .clk(clk), .Reset(Reset), .Sin(sin[2]), .rx_data(rd_c), .rx_valid(rv[2]),
    .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk[2]),
`endif
    .busy(bz[2]));

`ifndef UART_RX_BREAK_DETECT_EN
  assign brk = 3'b000;
`endif

  function automatic logic [8:0] get_rd(input int d);
    case (d)
      0:       return {1'b0, rd_a};
      1:       return {2'b00, rd_b};
      default: return {1'b0, rd_c};
    endcase
  endfunction

  // Frame-level model: what a receiver of configuration d must deliver
  function automatic exp_t model(input int d, input int data, input int pbit,
                                 input int s1, input int s2);
    exp_t e;
    int   masked;
    int   ones;
    masked = data & ((1 << DB[d]) - 1);
    ones   = $countones(masked);
    e.data = 9'(masked);
    e.pe   = (PEN[d] != 0) && (((ones + pbit) % 2) != PODD[d]);
    e.fe   = (s1 == 0) || (SB[d] == 2 && s2 == 0);
    return e;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int d, input logic b);
    sin[d] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input int data, input int pbit,
                            input int s1, input int s2, input bit load);
    if (load) expq[d].push_back(model(d, data, pbit, s1, s2));
    else      exp_ovr[d] = 1;
    drive_bit(d, 1'b0);
    for (int i = 0; i < DB[d]; i++) drive_bit(d, 1'((data >> i) & 1));
    if (PEN[d] != 0) drive_bit(d, 1'(pbit));
    drive_bit(d, 1'(s1));
    if (SB[d] == 2) drive_bit(d, 1'(s2));
    sin[d] = 1'b1;
  endtask

  task automatic wait_valid(input int d, input int budget);
    int n;
    n = 0;
    while (!rv[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!rv[d]) begin
      n_fail++;
      $display("FAIL wait_valid dut%0d: rx_valid 0 after %0d cycles, required 1", d, budget);
    end
  endtask

  // Literal check of a held word {data, parity_err, frame_err, overrun}, then release it
  task automatic held_check(input int d, input logic [8:0] xd, input logic xpe,
                            input logic xfe, input logic xov);
    wait_valid(d, 4 * CPB);
    check_val($sformatf("held_word_dut%0d", d), {get_rd(d), pe[d], fe[d], ov[d]},
              {xd, xpe, xfe, xov});
    @(negedge clk);
    rdy[d] = 1'b1;
    @(negedge clk);
    rdy[d] = 1'b0;
    #2;
    check_val($sformatf("released_valid_overrun_dut%0d", d), {rv[d], ov[d]}, 2'b00);
  endtask

  // Compare process: every cycle a word is held it must match the model's next word
  always begin
    @(negedge clk);
    #1;
    if (!Reset) begin
      for (int d = 0; d < 3; d++) begin
        if (brk[d]) bcnt[d]++;
        if (rv[d]) begin
          vcnt[d]++;
          if (expq[d].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word dut%0d: got rx_valid=1 data %0h, required no word",
                     d, get_rd(d));
          end else begin
            check_val($sformatf("word_dut%0d", d), {get_rd(d), pe[d], fe[d]},
                      {expq[d][0].data, expq[d][0].pe, expq[d][0].fe});
            if (rdy[d]) begin
              check_val($sformatf("overrun_at_accept_dut%0d", d), ov[d], exp_ovr[d]);
              void'(expq[d].pop_front());
              exp_ovr[d] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   v0, b0;
    logic seen_busy;
    for (int d = 0; d < 3; d++) begin
      exp_ovr[d] = 0;
      vcnt[d]    = 0;
      bcnt[d]    = 0;
    end
    Reset = 1'b1;
    sin   = 3'b111;
    rdy   = 3'b111;
    idle(3);
    #2;
    for (int d = 0; d < 3; d++)
      check_val($sformatf("reset_state_dut%0d", d),
                {get_rd(d), rv[d], pe[d], fe[d], ov[d], bz[d], brk[d]}, 0);
    @(negedge clk);
    Reset = 1'b0;
    idle(4);

    // Basic frame, consumer always ready: one-cycle valid
    v0 = vcnt[0];
    send_frame(0, 'hA5, 1, 1, 1, 1);
    idle(20);
    check_val("basic_valid_cycles", vcnt[0] - v0, 1);

    // Parity error with odd parity
    rdy[0] = 1'b0;
    send_frame(0, 'hA5, 0, 1, 1, 1);
    held_check(0, 9'h0A5, 1'b1, 1'b0, 1'b0);

    // Even-parity receiver, parity bit 0 is correct for 0xA5
    rdy[2] = 1'b0;
    send_frame(2, 'hA5, 0, 1, 1, 1);
    held_check(2, 9'h0A5, 1'b0, 1'b0, 1'b0);

    // Framing error
    send_frame(0, 'h3C, 1, 0, 1, 1);
    held_check(0, 9'h03C, 1'b0, 1'b1, 1'b0);

    // 5-cycle glitch: start seen, rejected, no word
    rdy[0] = 1'b1;
    idle(4);
    seen_busy = 1'b0;
    sin[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bz[0]) seen_busy = 1'b1;
    end
    sin[0] = 1'b1;
    check_val("glitch_busy_seen", seen_busy, 1'b1);
    for (int i = 0; i < 10 && bz[0]; i++) @(negedge clk);
    check_val("glitch_busy_cleared", bz[0], 1'b0);
    idle(40);

    // Overrun: second frame dropped, first retained
    rdy[0] = 1'b0;
    send_frame(0, 'h11, 1, 1, 1, 1);
    send_frame(0, 'h22, 1, 1, 1, 0);
    idle(5);
    held_check(0, 9'h011, 1'b0, 1'b0, 1'b1);

    // 7-bit, no parity, 2 stops: second stop low
    rdy[1] = 1'b0;
    send_frame(1, 'h55, 0, 1, 0, 1);
    held_check(1, 9'h055, 1'b0, 1'b1, 1'b0);
    idle(10);

    // Reset in the middle of the data bits
    drive_bit(1, 1'b0);
    drive_bit(1, 1'b1);
    drive_bit(1, 1'b0);
    Reset  = 1'b1;
    sin[1] = 1'b1;
    idle(2);
    #2;
    check_val("midframe_reset_dut1",
              {get_rd(1), rv[1], pe[1], fe[1], ov[1], bz[1], brk[1]}, 0);
    @(negedge clk);
    Reset = 1'b0;
    idle(10);
    send_frame(1, 'h2A, 0, 1, 1, 1);
    held_check(1, 9'h02A, 1'b0, 1'b0, 1'b0);

    // Break: line held low for 20 bit periods
    rdy[0] = 1'b0;
    idle(10);
    b0 = bcnt[0];
`ifndef UART_RX_BREAK_DETECT_EN
    expq[0].push_back(model(0, 0, 0, 0, 0));
`endif
    sin[0] = 1'b0;
    idle(20 * CPB);
    sin[0] = 1'b1;
    idle(40);
`ifdef UART_RX_BREAK_DETECT_EN
    check_val("break_pulses", bcnt[0] - b0, 1);
    check_val("break_no_word_not_busy", {rv[0], bz[0]}, 2'b00);
`else
    check_val("break_no_pulse", bcnt[0] - b0, 0);
    held_check(0, 9'h000, 1'b1, 1'b1, 1'b0);
    idle(20);
`endif

    for (int d = 0; d < 3; d++)
      check_val($sformatf("queue_drained_dut%0d", d), expq[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
